// File: rtl/stdcell_bist_pkg.sv
// Shared types and helpers for the standard-cell BIST controller.
package stdcell_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } bist_state_t;

    // Feedback taps 8,6,5,4 of the 8-bit pattern LFSR (bits 7,5,4,3).
    localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam int          MISR_MAX_W   = 32;

    // One MISR step for a w-bit register held right-aligned in a 32-bit word.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] poly,
        input logic                  din,
        input int                    w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        logic                  msb;
        mask = {MISR_MAX_W{1'b1}} >> (MISR_MAX_W - w);
        msb  = |(sig & (MISR_MAX_W'(1) << (w - 1)));
        nxt  = (sig << 1) ^ (msb ? poly : '0) ^ {{(MISR_MAX_W-1){1'b0}}, din};
        return nxt & mask;
    endfunction

endpackage

// File: rtl/stdcell_bist_misr.sv
// Serial-input MISR that compacts the cell-under-test response stream.
module bist_misr
    import stdcell_bist_pkg::*;
#(
    parameter int            W    = 16,
    parameter logic [W-1:0]  POLY = W'(DEFAULT_POLY)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic         serial_in,
    output logic [W-1:0] signature
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= '0;
        end else if (clear) begin
            signature <= '0;
        end else if (enable) begin
            signature <= W'(misr_next(MISR_MAX_W'(signature), MISR_MAX_W'(POLY), serial_in, W));
        end
    end

endmodule

// File: rtl/stdcell_bist_ctrl.sv
// BIST controller: LFSR stimulus to one combinational cell, MISR compaction, golden compare.
// Define STDCELL_BIST_EXHAUSTIVE_EN to replace the LFSR with an exhaustive N_IN-bit counter.
module stdcell_bist_ctrl
    import stdcell_bist_pkg::*;
#(
    parameter int                N_IN   = 3,
    parameter int                LFSR_W = 8,
    parameter logic [7:0]        SEED   = 8'h01,
    parameter int                N_PAT  = 255,
    parameter int                MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY),
    parameter logic [MISR_W-1:0] GOLDEN = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   cut_in,
    input  logic              cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output bist_state_t       dbg_state
);

`ifdef STDCELL_BIST_EXHAUSTIVE_EN
    localparam int EFF_PAT = 1 << N_IN;
`else
    localparam int EFF_PAT = N_PAT;
`endif
    localparam int                CNT_W    = $clog2(EFF_PAT + 1);
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 8'h00) ? LFSR_W'(1) : LFSR_W'(SEED);

    bist_state_t       state;
    logic [LFSR_W-1:0] pat;
    logic [LFSR_W-1:0] pat_init;
    logic [LFSR_W-1:0] pat_next;
    logic [CNT_W-1:0]  count;
    logic [MISR_W-1:0] sig_next;

`ifdef STDCELL_BIST_EXHAUSTIVE_EN
    assign pat_init = '0;
    assign pat_next = pat + LFSR_W'(1);
`else
    assign pat_init = SEED_EFF;
    assign pat_next = {pat[LFSR_W-2:0], ^(pat & LFSR_W'(LFSR_TAPS))};
`endif

    // Signature the MISR will hold after absorbing the current response.
    assign sig_next  = MISR_W'(misr_next(MISR_MAX_W'(signature), MISR_MAX_W'(POLY), cut_out, MISR_W));
    assign dbg_state = state;

    // start is a single-cycle request; it is accepted only in IDLE/DONE, busy high means it is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pat    <= '0;
            cut_in <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                LOAD: begin
                    pat    <= pat_init;
                    cut_in <= pat_init[N_IN-1:0];
                    count  <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    pat    <= pat_next;
                    cut_in <= pat_next[N_IN-1:0];
                    count  <= count + CNT_W'(1);
                    if (count == CNT_W'(EFF_PAT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (sig_next == GOLDEN);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    bist_misr #(
        .W    (MISR_W),
        .POLY (POLY)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == LOAD),
        .enable    (state == RUN),
        .serial_in (cut_out),
        .signature (signature)
    );

endmodule

// File: tb/tb_stdcell_bist_ctrl.sv
// Bench for stdcell_bist_ctrl: four instances with different pattern counts driven by a random truth-table cell.
module tb_stdcell_bist_ctrl;
    import stdcell_bist_pkg::*;

    localparam int NDUT = 4;

    function automatic int np_of(input int g);
        case (g)
            0:       return 4;
            1:       return 2;
            2:       return 1;
            default: return 40;
        endcase
    endfunction

    function automatic int seed_of(input int g);
        case (g)
            0:       return 'h01;
            1:       return 'h3C;
            2:       return 'hA5;
            default: return 'h00;
        endcase
    endfunction

    function automatic int golden_of(input int g);
        return (g == 2) ? 1 : 0;
    endfunction

    function automatic int eff_of(input int g);
`ifdef STDCELL_BIST_EXHAUSTIVE_EN
        return 8 + 0 * g;
`else
        return np_of(g);
`endif
    endfunction

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NDUT-1:0] start_v;
    logic [7:0]      tt;
    logic [2:0]      cut_in_w [NDUT];
    logic [NDUT-1:0] cut_out_w;
    logic [NDUT-1:0] busy_w;
    logic [NDUT-1:0] done_w;
    logic [NDUT-1:0] pass_w;
    logic [15:0]     sig_w [NDUT];
    bist_state_t     st_w [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        stdcell_bist_ctrl #(
            .N_IN   (3),
            .N_PAT  (np_of(g)),
            .SEED   (8'(seed_of(g))),
            .GOLDEN (16'(golden_of(g)))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_v[g]),
            .cut_in    (cut_in_w[g]),
            .cut_out   (cut_out_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .pass      (pass_w[g]),
            .signature (sig_w[g]),
            .dbg_state (st_w[g])
        );
        assign cut_out_w[g] = tt[cut_in_w[g]];
    end

    // scoreboard
    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_pat [NDUT][64];
    int         exp_sig [NDUT];
    logic       exp_pass [NDUT];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: LFSR/counter pattern list and MISR fold computed straight from the rules.
    task automatic build_model(input int g, input logic [7:0] t);
        int v;
        int sig;
        int p;
        int msb;
        v = seed_of(g);
        if (v == 0) v = 1;
        sig = 0;
        for (int k = 0; k < eff_of(g); k++) begin
`ifdef STDCELL_BIST_EXHAUSTIVE_EN
            p = k % 8;
`else
            p = v % 8;
`endif
            exp_pat[g][k] = 3'(p);
            msb = (sig >> 15) & 1;
            sig = ((sig << 1) ^ (msb != 0 ? 'h1021 : 0) ^ int'(t[p])) & 'hFFFF;
            v = ((v << 1) & 'hFF) | (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
        end
        exp_sig[g]  = sig;
        exp_pass[g] = (sig == golden_of(g));
    endtask

    task automatic check_idle(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check_eq($sformatf("%s state g%0d", tag, g), 32'(st_w[g]), 32'(IDLE));
            check_eq($sformatf("%s busy g%0d", tag, g), 32'(busy_w[g]), 0);
            check_eq($sformatf("%s done g%0d", tag, g), 32'(done_w[g]), 0);
            check_eq($sformatf("%s pass g%0d", tag, g), 32'(pass_w[g]), 0);
            check_eq($sformatf("%s sig g%0d", tag, g), 32'(sig_w[g]), 0);
            check_eq($sformatf("%s cut_in g%0d", tag, g), 32'(cut_in_w[g]), 0);
        end
    endtask

    // Run every instance once. Cycle c counts edges from the one that samples start (c=1).
    task automatic do_run(input logic [7:0] t, input int mid_at, input int rst_at);
        int         maxc;
        int         e;
        logic [31:0] fold;
        logic [7:0]  resp;
        tt   = t;
        maxc = 0;
        for (int g = 0; g < NDUT; g++) begin
            build_model(g, t);
            if (eff_of(g) + 4 > maxc) maxc = eff_of(g) + 4;
        end
        exp_q.delete();
`ifdef STDCELL_BIST_EXHAUSTIVE_EN
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
`else
        exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd4); exp_q.push_back(3'd0);
`endif
        @(negedge clk);
        start_v = '1;
        @(negedge clk);
        for (int c = 1; c <= maxc; c++) begin
            start_v = '0;
            for (int g = 0; g < NDUT; g++) begin
                e = eff_of(g);
                if (c == 1) begin
                    check_eq($sformatf("busy@load g%0d", g), 32'(busy_w[g]), 1);
                    check_eq($sformatf("done@load g%0d", g), 32'(done_w[g]), 0);
                end
                if (c >= 2 && c <= e + 1) begin
                    check_eq($sformatf("cut_in g%0d c%0d", g, c), 32'(cut_in_w[g]), 32'(exp_pat[g][c-2]));
                end
                if (c == e + 1) check_eq($sformatf("done early g%0d", g), 32'(done_w[g]), 0);
                if (c >= e + 2 && c <= e + 4) begin
                    check_eq($sformatf("done g%0d c%0d", g, c), 32'(done_w[g]), 1);
                    check_eq($sformatf("busy@done g%0d", g), 32'(busy_w[g]), 0);
                    check_eq($sformatf("sig g%0d c%0d", g, c), 32'(sig_w[g]), 32'(exp_sig[g]));
                    check_eq($sformatf("pass g%0d", g), 32'(pass_w[g]), 32'(exp_pass[g]));
                end
                if (c == e + 2) begin
                    check_eq($sformatf("state@done g%0d", g), 32'(st_w[g]), 32'(DONE));
`ifdef STDCELL_BIST_EXHAUSTIVE_EN
                    if (t == 8'h1F) begin
                        resp = 8'b0001_1111;
                        fold = '0;
                        for (int k = 0; k < 8; k++) fold = misr_next(fold, 32'h1021, resp[k], 16);
                        check_eq($sformatf("oai21 fold g%0d", g), 32'(sig_w[g]), fold);
                    end
`else
                    if (t == 8'h00 && g == 0) begin
                        check_eq("tied0 sig", 32'(sig_w[g]), 32'h0000);
                        check_eq("tied0 pass", 32'(pass_w[g]), 1);
                    end
                    if (t == 8'hFF && g == 1) begin
                        check_eq("tied1 n2 sig", 32'(sig_w[g]), 32'h0003);
                        check_eq("tied1 n2 pass", 32'(pass_w[g]), 0);
                    end
                    if (t == 8'hFF && g == 2) check_eq("tied1 n1 sig", 32'(sig_w[g]), 32'h0001);
`endif
                end
            end
            if (c >= 2 && c <= 5) begin
                if (exp_q.size() == 0) check_eq("exp_q underflow", 1, 0);
                else check_eq($sformatf("seq g0 c%0d", c), 32'(cut_in_w[0]), 32'(exp_q.pop_front()));
            end
            if (c == mid_at) start_v = 4'b1000;
            if (c == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_idle("midreset");
                rst_n   = 1'b1;
                start_v = '0;
                return;
            end
            @(negedge clk);
        end
        start_v = '0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        tt      = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        do_run(8'h00, 0, 0);
        do_run(8'hFF, 0, 0);
        do_run(8'h1F, 5, 0);
        do_run(8'h1F, 0, 0);
        repeat (4) do_run(8'($urandom_range(0, 255)), 0, 0);
        do_run(8'($urandom_range(0, 255)), 0, 8);
        do_run(8'($urandom_range(0, 255)), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
